// File: rtl/mio_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter_if
// Bundle of the two master request channels and the shared slave bus.
//   cpu_*      : CPU request channel (req/wr/addr/wdata in, ready/rdata out)
//   dma_*      : secondary mover request channel, same shape as CPU
//   bus_*      : shared slave bus (en/we/addr/wdata out, rdata in)
//   grant      : one-hot current owner, [0]=CPU, [1]=DMA, 00 idle
// Modports:
//   master : arbiter side (drives the bus, ready pulses and grant)
//   slave  : environment side (masters + slave device)
// ---------------------------------------------------------------------------
interface mio_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_wr;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_rdata;

  logic              bus_en;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  logic [1:0]        grant;

  modport master (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    input  bus_rdata,
    output cpu_ready, cpu_rdata, dma_ready, dma_rdata,
    output bus_en, bus_we, bus_addr, bus_wdata, grant
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    output bus_rdata,
    input  cpu_ready, cpu_rdata, dma_ready, dma_rdata,
    input  bus_en, bus_we, bus_addr, bus_wdata, grant
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter
// Two-master arbiter for one shared fixed-latency memory/IO bus.
// CPU has priority; a starvation counter forces a DMA grant after
// STARVE_MAX consecutive CPU grants while DMA is waiting.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : mio_bus_arbiter_if.master (request channels, slave bus, grant)
// Parameters:
//   ADDR_W/DATA_W : bus widths
//   WAIT_CYC      : cycles bus_en is held per access (1..15)
//   STARVE_MAX    : CPU grants allowed while DMA pends (1..15)
// ---------------------------------------------------------------------------

// Per-master completion lane: ready pulse and read-data hold register.
//   fin_i  : access finishes on this edge
//   own_i  : this lane owns the current access
//   rd_i   : current access is a read
module mio_arb_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fin_i,
  input  logic              own_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    ready_d = fin_i & own_i;
    rdata_d = rdata_q;
    // writes leave the held read data untouched
    if (fin_i && own_i && rd_i) rdata_d = bus_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
endmodule

module mio_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAIT_CYC   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mio_bus_arbiter_if.master  bus
);
  // lane 0 = CPU, lane 1 = DMA; grant bit m belongs to lane m
  localparam int         NUM_M      = 2;
  localparam logic [3:0] WAIT_LD    = 4'(WAIT_CYC - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  req_t [NUM_M-1:0] req;
  logic [NUM_M-1:0] req_vld;

  assign req[0]     = '{wr: bus.cpu_wr, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign req[1]     = '{wr: bus.dma_wr, addr: bus.dma_addr, wdata: bus.dma_wdata};
  assign req_vld[0] = bus.cpu_req;
  assign req_vld[1] = bus.dma_req;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [3:0]        starve_q, starve_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [NUM_M-1:0]  grant_q, grant_d;

  logic              fin;
  logic              dma_win, cpu_win, win_idx;
  logic [DATA_W-1:0] bus_rdata;
  logic [NUM_M-1:0]  m_ready;
  logic [NUM_M-1:0][DATA_W-1:0] m_rdata;

  assign bus_rdata = bus.bus_rdata;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    bus_en_d    = bus_en_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    grant_d     = grant_q;
    fin         = 1'b0;

    // DMA wins when the CPU is quiet or has used up its run of grants
    dma_win = req_vld[1] && (!req_vld[0] || starve_q == STARVE_LIM);
    cpu_win = !dma_win && req_vld[0];
    win_idx = dma_win;

    case (state_q)
      S_IDLE: begin
        if (dma_win || cpu_win) begin
          bus_en_d    = 1'b1;
          bus_we_d    = req[win_idx].wr;
          bus_addr_d  = req[win_idx].addr;
          bus_wdata_d = req[win_idx].wdata;
          grant_d     = dma_win ? 2'b10 : 2'b01;
          wait_d      = WAIT_LD;
          state_d     = S_ACCESS;
          if (dma_win)
            starve_d = '0;
          else if (req_vld[1])
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
          else
            starve_d = '0;
        end
      end
      S_ACCESS: begin
        if (wait_q == '0) begin
          // lanes capture read data and raise ready on this edge
          fin      = 1'b1;
          bus_en_d = 1'b0;
          bus_we_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      bus_en_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      bus_en_q    <= bus_en_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      grant_q     <= grant_d;
    end
  end

  // grant stays set through ACCESS, so it selects the completing lane
  for (genvar m = 0; m < NUM_M; m++) begin : g_lane
    mio_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .fin_i      (fin),
      .own_i      (grant_q[m]),
      .rd_i       (~bus_we_q),
      .bus_rdata_i(bus_rdata),
      .ready_o    (m_ready[m]),
      .rdata_o    (m_rdata[m])
    );
  end

  assign bus.cpu_ready = m_ready[0];
  assign bus.cpu_rdata = m_rdata[0];
  assign bus.dma_ready = m_ready[1];
  assign bus.dma_rdata = m_rdata[1];
  assign bus.bus_en    = bus_en_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.grant     = grant_q;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
module tb_mio_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(rst_n), .bus(b1));
  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1), .STARVE_MAX(4)) dut_w1 (
    .clk(clk), .reset(rst_n), .bus(b2));

  typedef struct {
    logic        creq;  logic [31:0] caddr;
    logic        dreq;  logic        dwr;   logic [31:0] daddr; logic [31:0] dwd;
    logic [31:0] brd;   logic [1:0]  push;
    logic        en;    logic        we;    logic [31:0] addr;  logic [31:0] wd;
    logic [1:0]  g;     logic        crdy;  logic        drdy;
    logic [31:0] crd;   logic [31:0] drd;
  } vec_t;

  typedef struct {
    logic [1:0] own; logic wr; logic [31:0] addr; logic [31:0] rd;
  } exp_t;

  localparam logic [31:0] DB = 32'hDEADBEEF, BB = 32'hBADBAD00, CF = 32'hCAFEF00D, Z = 32'h0;

  vec_t        vec [14];
  vec_t        v;
  exp_t        sbq [$];
  logic [1:0]  cont_own [10];
  int          errors = 0, checks = 0, cyc = 0;
  logic        prev_en = 1'b0, new_grant = 1'b0, cap_we = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [1:0]  cap_own = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // advance one cycle, sample #1 after the edge, run the scoreboard on DUT1
  task automatic tick();
    exp_t e;
    @(posedge clk); #1; cyc++;
    new_grant = b1.bus_en && !prev_en;
    if (new_grant) begin
      cap_addr = b1.bus_addr; cap_we = b1.bus_we; cap_own = b1.grant;
    end
    prev_en = b1.bus_en;
    chk("ready_excl", 32'(b1.cpu_ready & b1.dma_ready), Z);
    chk("we_qual", 32'(b1.bus_we & ~b1.bus_en), Z);
    if (b1.cpu_ready || b1.dma_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: ready %b%b with no expected transaction (cycle %0d)",
                 b1.dma_ready, b1.cpu_ready, cyc);
      end else begin
        e = sbq.pop_front();
        chk("sb_owner", 32'({b1.dma_ready, b1.cpu_ready}), 32'(e.own));
        chk("sb_grant", 32'(cap_own), 32'(e.own));
        chk("sb_addr", cap_addr, e.addr);
        chk("sb_wr", 32'(cap_we), 32'(e.wr));
        if (!e.wr) chk("sb_rdata", (e.own == 2'b01) ? b1.cpu_rdata : b1.dma_rdata, e.rd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gidx, last;
    vec[0]  = '{1'b1,32'h10,1'b0,1'b0,Z,Z,DB,2'd1, 1'b1,1'b0,32'h10,Z,2'b01,1'b0,1'b0,Z,Z};
    vec[1]  = '{1'b1,32'h10,1'b0,1'b0,Z,Z,DB,2'd0, 1'b1,1'b0,32'h10,Z,2'b01,1'b0,1'b0,Z,Z};
    vec[2]  = '{1'b1,32'h10,1'b0,1'b0,Z,Z,DB,2'd0, 1'b0,1'b0,Z,Z,2'b01,1'b1,1'b0,DB,Z};
    vec[3]  = '{1'b0,32'h10,1'b0,1'b0,Z,Z,DB,2'd0, 1'b0,1'b0,Z,Z,2'b00,1'b0,1'b0,DB,Z};
    vec[4]  = '{1'b0,Z,1'b1,1'b1,32'h2000,32'h12345678,BB,2'd2,
                1'b1,1'b1,32'h2000,32'h12345678,2'b10,1'b0,1'b0,DB,Z};
    vec[5]  = '{1'b0,Z,1'b1,1'b1,32'h2000,32'h12345678,BB,2'd0,
                1'b1,1'b1,32'h2000,32'h12345678,2'b10,1'b0,1'b0,DB,Z};
    vec[6]  = '{1'b0,Z,1'b0,1'b1,32'h2000,32'h12345678,BB,2'd0,
                1'b0,1'b0,Z,Z,2'b10,1'b0,1'b1,DB,Z};
    vec[7]  = '{1'b0,Z,1'b0,1'b0,Z,Z,BB,2'd0, 1'b0,1'b0,Z,Z,2'b00,1'b0,1'b0,DB,Z};
    vec[8]  = '{1'b1,32'h10,1'b0,1'b0,Z,Z,CF,2'd1, 1'b1,1'b0,32'h10,Z,2'b01,1'b0,1'b0,DB,Z};
    vec[9]  = '{1'b0,32'h99,1'b0,1'b0,Z,Z,CF,2'd0, 1'b1,1'b0,32'h10,Z,2'b01,1'b0,1'b0,DB,Z};
    vec[10] = '{1'b0,32'h99,1'b0,1'b0,Z,Z,CF,2'd0, 1'b0,1'b0,Z,Z,2'b01,1'b1,1'b0,CF,Z};
    for (int i = 11; i < 14; i++)
      vec[i] = '{1'b0,32'h99,1'b0,1'b0,Z,Z,CF,2'd0, 1'b0,1'b0,Z,Z,2'b00,1'b0,1'b0,CF,Z};

    b1.cpu_req = 0; b1.cpu_wr = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 0; b1.dma_wr = 0; b1.dma_addr = '0; b1.dma_wdata = '0; b1.bus_rdata = '0;
    b2.cpu_req = 0; b2.cpu_wr = 0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
    b2.dma_req = 0; b2.dma_wr = 0; b2.dma_addr = '0; b2.dma_wdata = '0; b2.bus_rdata = '0;

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst bus_en", 32'(b1.bus_en), Z);
    chk("rst bus_we", 32'(b1.bus_we), Z);
    chk("rst grant", 32'(b1.grant), Z);
    chk("rst readies", 32'({b1.cpu_ready, b1.dma_ready}), Z);
    chk("rst cpu_rdata", b1.cpu_rdata, Z);
    chk("rst dma_rdata", b1.dma_rdata, Z);
    chk("rst bus_addr", b1.bus_addr, Z);
    chk("rst w1 grant", 32'(b2.grant), Z);
    rst_n = 1'b1;
    tick();

    // table: CPU read, DMA write, CPU read with request drop and addr change
    for (int i = 0; i < 14; i++) begin
      v = vec[i];
      b1.cpu_req = v.creq; b1.cpu_addr = v.caddr; b1.cpu_wr = 1'b0;
      b1.dma_req = v.dreq; b1.dma_wr = v.dwr; b1.dma_addr = v.daddr; b1.dma_wdata = v.dwd;
      b1.bus_rdata = v.brd;
      if (v.push == 2'd1) sbq.push_back('{2'b01, 1'b0, v.caddr, v.brd});
      else if (v.push == 2'd2) sbq.push_back('{2'b10, v.dwr, v.daddr, v.brd});
      tick();
      chk($sformatf("v%0d bus_en", i), 32'(b1.bus_en), 32'(v.en));
      chk($sformatf("v%0d bus_we", i), 32'(b1.bus_we), 32'(v.we));
      chk($sformatf("v%0d grant", i), 32'(b1.grant), 32'(v.g));
      chk($sformatf("v%0d cpu_ready", i), 32'(b1.cpu_ready), 32'(v.crdy));
      chk($sformatf("v%0d dma_ready", i), 32'(b1.dma_ready), 32'(v.drdy));
      chk($sformatf("v%0d cpu_rdata", i), b1.cpu_rdata, v.crd);
      chk($sformatf("v%0d dma_rdata", i), b1.dma_rdata, v.drd);
      if (v.en) chk($sformatf("v%0d bus_addr", i), b1.bus_addr, v.addr);
      if (v.en && v.we) chk($sformatf("v%0d bus_wdata", i), b1.bus_wdata, v.wd);
    end

    // contention: both requests held, CPU x4 then DMA, repeating
    for (int k = 0; k < 10; k++) begin
      cont_own[k] = (k % 5 == 4) ? 2'b10 : 2'b01;
      sbq.push_back('{cont_own[k], 1'b0, (k % 5 == 4) ? 32'h200 : 32'h100, 32'h55AA1234});
    end
    b1.cpu_req = 1; b1.cpu_addr = 32'h100; b1.dma_req = 1; b1.dma_wr = 0;
    b1.dma_addr = 32'h200; b1.bus_rdata = 32'h55AA1234;
    gidx = 0; last = 0;
    for (int budget = 0; budget < 80 && gidx < 10; budget++) begin
      tick();
      if (new_grant) begin
        chk($sformatf("cont grant%0d", gidx), 32'(b1.grant), 32'(cont_own[gidx]));
        if (gidx > 0) chk("cont spacing", 32'(cyc - last), 32'd4);
        last = cyc;
        gidx++;
        if (gidx == 10) begin b1.cpu_req = 0; b1.dma_req = 0; end
      end
    end
    if (gidx < 10) begin
      checks++; errors++;
      $display("FAIL cont_timeout: got %0d grants want 10", gidx);
      b1.cpu_req = 0; b1.dma_req = 0;
    end
    repeat (4) tick();
    chk("cont drained", 32'(sbq.size()), Z);
    chk("cont idle grant", 32'(b1.grant), Z);

    // reset in cycle 2 of a CPU read abandons it
    b1.cpu_req = 1; b1.cpu_addr = 32'h40; b1.bus_rdata = 32'h0BADF00D;
    tick();
    chk("rstmid c1 bus_en", 32'(b1.bus_en), 32'd1);
    chk("rstmid c1 grant", 32'(b1.grant), 32'd1);
    b1.cpu_req = 0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid bus_en", 32'(b1.bus_en), Z);
    chk("rstmid grant", 32'(b1.grant), Z);
    chk("rstmid cpu_ready", 32'(b1.cpu_ready), Z);
    chk("rstmid cpu_rdata", b1.cpu_rdata, Z);
    tick();
    chk("rstmid hold cpu_ready", 32'(b1.cpu_ready), Z);
    rst_n = 1'b1;
    tick();
    chk("rstmid release grant", 32'(b1.grant), Z);
    b1.cpu_req = 1; b1.cpu_addr = 32'h44; b1.bus_rdata = 32'h77;
    sbq.push_back('{2'b01, 1'b0, 32'h44, 32'h77});
    tick();
    chk("after rst grant", 32'(b1.grant), 32'd1);
    chk("after rst addr", b1.bus_addr, 32'h44);
    b1.cpu_req = 0;
    tick(); tick();
    chk("after rst ready", 32'(b1.cpu_ready), 32'd1);
    tick();
    chk("after rst grant idle", 32'(b1.grant), Z);

    // WAIT_CYC=1: back-to-back CPU reads at 0x4 then 0x8
    b2.cpu_req = 1; b2.cpu_addr = 32'h4; b2.bus_rdata = 32'h11111111;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("w1 c%0d bus_en", c), 32'(b2.bus_en), 32'(c == 1 || c == 4));
      chk($sformatf("w1 c%0d cpu_ready", c), 32'(b2.cpu_ready), 32'(c == 2 || c == 5));
      if (c == 1) begin chk("w1 addr0", b2.bus_addr, 32'h4); b2.cpu_addr = 32'h8; end
      if (c == 2) begin chk("w1 rdata0", b2.cpu_rdata, 32'h11111111); b2.bus_rdata = 32'h22222222; end
      if (c == 4) begin chk("w1 addr1", b2.bus_addr, 32'h8); b2.cpu_req = 0; end
      if (c == 5) chk("w1 rdata1", b2.cpu_rdata, 32'h22222222);
    end

    chk("sb empty", 32'(sbq.size()), Z);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Arbitrates one shared memory/IO bus between two masters: the CPU (its CPU_MIO/WR/Addr_out/Data_out side, with MIO_ready returned) and a secondary DMA-style master (e.g. a VRAM/peripheral mover).
- Runs fixed-latency slave accesses and pulses a one-cycle ready back to the granted master.
- CPU has priority; a starvation counter guarantees the DMA master a grant.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYC, 2, cycles bus_en is held per access (legal range 1..15).
- STARVE_MAX, 4, consecutive CPU grants allowed while dma_req is pending (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request (from CPU_MIO).
- cpu_wr  in  1  CPU write=1 / read=0.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  one-cycle completion pulse (to MIO_ready).
- cpu_rdata  out  DATA_W  last CPU read data.
- dma_req  in  1  DMA request.
- dma_wr  in  1  DMA write=1 / read=0.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_ready  out  1  one-cycle completion pulse.
- dma_rdata  out  DATA_W  last DMA read data.
- bus_en  out  1  slave select, high during an access.
- bus_we  out  1  slave write enable, qualified by bus_en.
- bus_addr  out  ADDR_W  slave address.
- bus_wdata  out  DATA_W  slave write data.
- bus_rdata  in  DATA_W  slave read data, valid by the last access cycle.
- grant  out  2  one-hot owner: [0]=CPU, [1]=DMA; 00 means idle.

Behaviour:
- Reset is sampled on the clk edge while reset==0. It forces:
  - state to IDLE, starve_cnt to 0, wait counter to 0;
  - all outputs to 0, including both rdata registers and grant.
- States: IDLE, ACCESS, DONE.
- IDLE, winner selection:
  - If dma_req && (!cpu_req || starve_cnt==STARVE_MAX), DMA wins.
  - Else, if cpu_req, CPU wins.
  - Else, stay in IDLE.
- IDLE, on a win (same edge):
  - Latch the winner's addr/wdata/wr into bus_addr/bus_wdata/bus_we.
  - Set bus_en=1 and grant to the winner.
  - Load the wait counter with WAIT_CYC-1 and go to ACCESS.
- starve_cnt update, on each win:
  - CPU win with dma_req high: starve_cnt increments, saturating at STARVE_MAX.
  - CPU win with dma_req low: starve_cnt clears to 0.
  - DMA win: starve_cnt clears to 0.
- ACCESS:
  - bus_en, bus_we, bus_addr and bus_wdata are held stable.
  - The counter decrements each cycle.
  - When the counter is 0: for a read, capture bus_rdata into the owner's rdata register. Then deassert bus_en/bus_we, assert the owner's ready, and go to DONE.
- DONE:
  - Owner's ready=1 for exactly this cycle; grant still shows the owner.
  - Next edge: ready=0, grant=00, go to IDLE.
  - Requests are not evaluated in DONE.
- Latency: a request seen at IDLE edge 0 gives bus_en high for cycles 1..WAIT_CYC and ready high in cycle WAIT_CYC+1. Minimum spacing between back-to-back grants is WAIT_CYC+2 cycles.
- Inputs are sampled only at grant. Changes to addr/wdata/wr or req during ACCESS are ignored.
- Request dropped mid-access: no abort. The access completes and ready still pulses.
- Writes never modify cpu_rdata or dma_rdata. Each rdata register holds its value until the owning master's next read completes.
- The non-owner's ready is always 0. The two ready signals are never high together.
- Reset asserted during ACCESS or DONE: the transaction is abandoned, no ready pulse, bus_en=0 on the next cycle.
- bus_we=1 only while bus_en=1.

Test Plan:
- CPU read alone (WAIT_CYC=2), cpu_req=1 with addr 0x10 at cycle 0, bus_rdata=0xDEADBEEF:
  - bus_en=1 with bus_addr=0x10 and bus_we=0 in cycles 1-2;
  - cpu_ready=1 only in cycle 3; cpu_rdata=0xDEADBEEF; grant=01 in cycles 1-3, 00 in cycle 4.
- DMA write alone, dma_addr 0x2000, dma_wdata 0x12345678:
  - bus_we=1 and bus_wdata=0x12345678 in cycles 1-2;
  - dma_ready pulses in cycle 3; dma_rdata and cpu_rdata unchanged.
- Contention, STARVE_MAX=4, cpu_req and dma_req held high:
  - grant sequence is CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA, …;
  - exactly one ready per transaction, each spaced 4 cycles.
- Reset at cycle 2 of a CPU access:
  - bus_en=0, grant=00, cpu_ready never pulses, cpu_rdata=0;
  - after release, a new cpu_req is granted normally.
- cpu_req dropped in cycle 1 and cpu_addr changed to 0x99 mid-access:
  - bus_addr stays 0x10 and cpu_ready still pulses in cycle 3;
  - no further grant while both requests are low.
- WAIT_CYC=1, back-to-back CPU reads at addr 0x4 then 0x8:
  - ready in cycles 2 and 5;
  - bus_en high only in cycles 1 and 4.
